decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//   Instruction-decode (ID) stage of the 5-stage MIPS32 pipeline. Holds the 32x32 general register file.
//   Splits the fetched instruction into fields, reads the rs/rt operands and sign-extends the 16-bit immediate.
//   Registers these values, together with NPC and IR, into the ID/EX pipeline register.
//   Write-back is done by writing ALU_out into register rd.
// PARAMETERS
//   XLEN    32   datapath / register / instruction width (fixed; only 32 supported)
//   NREG    32   register-file depth; address width = 5
// PORTS
//   clk      in   1    sole clock; all state updates on rising edge
//   rst_n    in   1    reset, asynchronous, active-low
//   NPC_if   in   32   next-PC from the IF/ID register
//   IR_if    in   32   instruction from the IF/ID register
//   ALU_out  in   32   write-back data for register rd
//   A        out  32   registered operand reg[rs]
//   B        out  32   registered operand reg[rt]
//   Imm      out  32   registered sign-extended IR[15:0]
//   NPC_id   out  32   registered copy of NPC_if
//   IR_id    out  32   registered copy of IR_if
// BEHAVIOUR
//   - Fields of IR_if: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
//   - Reset (rst_n=0, asynchronous): A, B, Imm, NPC_id and IR_id go to 0 immediately.
//     All 32 register-file entries clear to 0. Reset held = state held at 0.
//   - Latency 1 cycle. At each rising clk edge with rst_n=1:
//       A      <= rd_val(rs)
//       B      <= rd_val(rt)
//       Imm    <= {{16{IR_if[15]}}, IR_if[15:0]}
//       NPC_id <= NPC_if
//       IR_id  <= IR_if
//   - Register-file write:
//       wen = (opcode == 6'b000000) && (rd != 0)   (R-type only)
//       When wen=1: reg[rd] <= ALU_out at the same edge.
//   - Register 0 is hardwired zero. It always reads 0, and any write to it is discarded.
//   - Read-during-write bypass: if wen=1 and rd==rs, A <= ALU_out (not the stale value). Same rule for B when rd==rt.
//     When rs==rt==rd, both A and B take ALU_out.
//   - No handshake and no stall: a new instruction is accepted every cycle. The outputs are pure pipeline registers.
//   - Reset released mid-stream: the first edge after release samples the current inputs normally.
//   - The register file must stay accessible as array `reg_b[0:31]` so a bench can preload it hierarchically.
// TESTING
//   1. Reset: assert rst_n=0 mid-cycle with nonzero state.
//      -> A, B, Imm, NPC_id and IR_id are 0 with no clock edge needed; all reg_b entries are 0.
//   2. Pass-through/imm+: NPC_if=0x4, IR_if=0x12345678, clk.
//      -> NPC_id=0x00000004, IR_id=0x12345678, Imm=0x00005678.
//      -> A=reg_b[17], B=reg_b[20]. No reg write (opcode 0x04).
//   3. Imm sign extension: IR_if=0xDEADBEEF, clk.
//      -> Imm=0xFFFFBEEF, A=reg_b[21], B=reg_b[13]. No write.
//   4. Write + bypass: IR_if=0x00210800 (rs=rt=rd=1), ALU_out=0xAAAABBBB, clk.
//      -> reg_b[1]=0xAAAABBBB, A=B=0xAAAABBBB in the same cycle.
//      -> Next instruction with rs=1 also reads 0xAAAABBBB.
//   5. r0 protection: preload reg_b[0]=0x12345678, then apply IR_if=0x00FF00FF (R-type, rd=0) with ALU_out=0xFFFF0000, clk.
//      -> No register changes. Reads of r0 return 0; A=reg_b[7], B=reg_b[31].
//   6. Back-to-back: three instructions on consecutive edges.
//      -> Each output set appears exactly one cycle after its input, with no bubbles.

Source files
------------

// File: rtl/decode_stage.sv
// MIPS32 instruction-decode stage: 32x32 register file with write-back bypass,
// field split, immediate sign extension and the ID/EX pipeline register.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] NPC_if,
  input  logic [XLEN-1:0] IR_if,
  input  logic [XLEN-1:0] ALU_out,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [XLEN-1:0] Imm,
  output logic [XLEN-1:0] NPC_id,
  output logic [XLEN-1:0] IR_id
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] reg_b [0:NREG-1];

  logic [5:0]      opcode_s;
  logic [AW-1:0]   rs_s;
  logic [AW-1:0]   rt_s;
  logic [AW-1:0]   rd_s;
  logic            wen_s;
  logic [XLEN-1:0] a_next_s;
  logic [XLEN-1:0] b_next_s;

  function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] val);
    return {{(XLEN-16){val[15]}}, val};
  endfunction

  assign opcode_s = IR_if[31:26];
  assign rs_s     = IR_if[25:21];
  assign rt_s     = IR_if[20:16];
  assign rd_s     = IR_if[15:11];
  assign wen_s    = (opcode_s == 6'b000000) && (rd_s != 5'd0);

  // Operand read: r0 reads zero, a same-cycle write to the source forwards ALU_out
  always_comb begin
    a_next_s = '0;
    b_next_s = '0;
    if (rs_s == 5'd0) begin
      a_next_s = '0;
    end else if (wen_s && (rd_s == rs_s)) begin
      a_next_s = ALU_out;
    end else begin
      a_next_s = reg_b[rs_s];
    end
    if (rt_s == 5'd0) begin
      b_next_s = '0;
    end else if (wen_s && (rd_s == rt_s)) begin
      b_next_s = ALU_out;
    end else begin
      b_next_s = reg_b[rt_s];
    end
  end

  // Register file write-back (R-type only; writes to r0 are dropped by wen_s)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        reg_b[i] <= '0;
      end
    end else if (wen_s) begin
      reg_b[rd_s] <= ALU_out;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A      <= '0;
      B      <= '0;
      Imm    <= '0;
      NPC_id <= '0;
      IR_id  <= '0;
    end else begin
      A      <= a_next_s;
      B      <= b_next_s;
      Imm    <= sign_ext16(IR_if[15:0]);
      NPC_id <= NPC_if;
      IR_id  <= IR_if;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a register-file model predicts each
// ID/EX output set; a monitor pops and compares one cycle after issue.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] npc_if;
  logic [31:0] ir_if;
  logic [31:0] alu_out;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] imm;
  logic [31:0] npc_id;
  logic [31:0] ir_id;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] npc;
    logic [31:0] ir;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] model_rf [0:31];
  int          n_checks;
  int          n_pass;

  decode_stage dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .NPC_if (npc_if),
    .IR_if  (ir_if),
    .ALU_out(alu_out),
    .A      (a),
    .B      (b),
    .Imm    (imm),
    .NPC_id (npc_id),
    .IR_id  (ir_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: commit the write-back, then read (gives same-cycle forwarding)
  function automatic exp_t predict(input logic [31:0] npc, input logic [31:0] ir, input logic [31:0] alu);
    exp_t e;
    int rs, rt, rd;
    rs = int'(ir[25:21]);
    rt = int'(ir[20:16]);
    rd = int'(ir[15:11]);
    if (ir[31:26] == 6'd0 && rd != 0) model_rf[rd] = alu;
    e.a   = (rs == 0) ? 32'h0 : model_rf[rs];
    e.b   = (rt == 0) ? 32'h0 : model_rf[rt];
    e.imm = 32'($signed(ir[15:0]));
    e.npc = npc;
    e.ir  = ir;
    return e;
  endfunction

  task automatic step(input logic [31:0] npc, input logic [31:0] ir, input logic [31:0] alu);
    @(negedge clk);
    npc_if  = npc;
    ir_if   = ir;
    alu_out = alu;
    if (rst_n) exp_q.push_back(predict(npc, ir, alu));
  endtask

  // Monitor: every edge consumes exactly one expectation issued on the previous half-cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("A", a, e.a);
        check("B", b, e.b);
        check("Imm", imm, e.imm);
        check("NPC_id", npc_id, e.npc);
        check("IR_id", ir_id, e.ir);
      end
    end
  end

  initial begin
    logic [31:0] r;
    int waited;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    npc_if   = 32'h0;
    ir_if    = 32'h0;
    alu_out  = 32'h0;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_A", a, 32'h0);
    check("reset_IR_id", ir_id, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill r1..r31 through R-type writes (add rd, r0, r0)
    for (int i = 1; i < 32; i++) step(32'(4 * i), {6'd0, 5'd0, 5'd0, 5'(i), 5'd0, 6'h20}, $urandom());

    step(32'h4, 32'h12345678, $urandom());
    step(32'h8, 32'hDEADBEEF, $urandom());
    step(32'hC, 32'h00210800, 32'hAAAABBBB);
    step(32'h10, 32'h8C220000, $urandom());
    // r0 protection: content planted in reg_b[0] must never be read or overwritten
    @(negedge clk);
    dut.reg_b[0] = 32'h12345678;
    step(32'h14, 32'h00FF00FF, 32'hFFFF0000);
    step(32'h18, 32'h00070000, $urandom());
    @(posedge clk);
    #2;
    check("r0_untouched", dut.reg_b[0], 32'h12345678);
    for (int i = 1; i < 32; i++) check("rf_entry", dut.reg_b[i], model_rf[i]);

    // Random back-to-back traffic, half R-type
    for (int k = 0; k < 300; k++) begin
      r = $urandom();
      if ($urandom_range(0, 1) == 0) r[31:26] = 6'd0;
      if ($urandom_range(0, 3) == 0) r[15:11] = r[25:21];
      step($urandom(), r, $urandom());
    end

    // Drain, then assert reset mid-cycle with live state
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_A", a, 32'h0);
    check("async_B", b, 32'h0);
    check("async_Imm", imm, 32'h0);
    check("async_NPC_id", npc_id, 32'h0);
    check("async_IR_id", ir_id, 32'h0);
    for (int i = 0; i < 32; i++) check("async_rf", dut.reg_b[i], 32'h0);
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    npc_if  = 32'h55;
    ir_if   = 32'h00421000;
    alu_out = 32'h77;
    repeat (2) @(posedge clk);
    #1;
    check("held_IR_id", ir_id, 32'h0);
    check("held_rf2", dut.reg_b[2], 32'h0);

    // Release mid-stream: first edge samples the live inputs
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(predict(npc_if, ir_if, alu_out));
    step(32'h60, 32'h00421800, 32'h99);
    step(32'h64, 32'h8C430000, $urandom());
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    check("final_drain", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
